// File: rtl/executor_acoes.sv
// executor_acoes: consumer end of the dog-toy action counter.
// Takes the action index presented by the counter, holds one actuator line
// high for DUR_ACAO cycles, waits PAUSA cycles and then pulses pulso_avanca
// once so the counter steps to its next index. With continuo=1 the block
// waits one settle cycle (ESPERA) after each advance and starts the next
// action by itself.
//
// Handshake: start is a level sampled on a rising edge. It is honoured only
// in IDLE with power=1, and is never queued. acao_in is sampled only on the
// edge that leaves IDLE or ESPERA.
//
// Every output is a flop. Its next value is decoded from the next state, so
// it changes cleanly on the clock edge and never glitches.
module executor_acoes #(
  parameter int DUR_W    = 8,
  parameter int DUR_ACAO = 50,
  parameter int PAUSA    = 10
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       power,
  input  logic       start,
  input  logic       continuo,
  input  logic [2:0] acao_in,
  output logic [5:0] atuador,
  output logic       pulso_avanca,
  output logic       ocupado,
  output logic       erro,
  output logic [7:0] acoes_feitas
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    PAUSA_ST = 3'd2,
    ESPERA   = 3'd3,
    ERRO_ST  = 3'd4
  } estado_t;

  // Timer reload values. A timer loaded with N-1 that counts down to 0
  // covers exactly N cycles.
  localparam logic [DUR_W-1:0] RUN_LOAD   = DUR_W'(DUR_ACAO - 1);
  localparam logic [DUR_W-1:0] PAUSA_LOAD = DUR_W'(PAUSA - 1);
  localparam logic [DUR_W-1:0] TIMER_ONE  = DUR_W'(1);

  estado_t          state_q, state_d;
  logic [DUR_W-1:0] timer_q, timer_d;
  logic [2:0]       code_q, code_d;
  logic [7:0]       count_q, count_d;
  logic [5:0]       atuador_q, atuador_d;
  logic             pulso_q, pulso_d;
  logic             ocupado_q, ocupado_d;
  logic             erro_q, erro_d;

  // The block may latch a new index only in IDLE with start, or in ESPERA
  // (where start is implied).
  logic aceita;
  // The final pause cycle is the one in which pulso_avanca is high.
  logic fim_pausa;

  // Decode of a valid index into the actuator line it drives.
  function automatic logic [5:0] one_hot(input logic [2:0] code);
    logic [5:0] r;
    r = '0;
    if (code <= 3'd5) begin
      r = 6'b000001 << code;
    end
    return r;
  endfunction

  // Next-state, timer, latched code and completion counter.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    code_d    = code_q;
    count_d   = count_q;
    aceita    = 1'b0;
    fim_pausa = (state_q == PAUSA_ST) && (timer_q == '0);

    if (!power) begin
      // Losing power abandons the current action without counting it.
      state_d = IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          aceita = start;
        end
        ESPERA: begin
          aceita = 1'b1;
        end
        RUN: begin
          if (timer_q == '0) begin
            state_d = PAUSA_ST;
            timer_d = PAUSA_LOAD;
          end else begin
            timer_d = timer_q - TIMER_ONE;
          end
        end
        PAUSA_ST: begin
          if (fim_pausa) begin
            count_d = count_q + 8'd1;
            state_d = continuo ? ESPERA : IDLE;
          end else begin
            timer_d = timer_q - TIMER_ONE;
          end
        end
        ERRO_ST: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase

      if (aceita) begin
        code_d = acao_in;
        if (acao_in <= 3'd5) begin
          state_d = RUN;
          timer_d = RUN_LOAD;
        end else begin
          state_d = ERRO_ST;
          timer_d = '0;
        end
      end
    end
  end

  // Output values for the next cycle, decoded from the next state.
  always_comb begin
    atuador_d = '0;
    pulso_d   = 1'b0;
    erro_d    = 1'b0;
    ocupado_d = (state_d != IDLE);
    if (state_d == RUN) begin
      atuador_d = one_hot(code_d);
    end
    if ((state_d == PAUSA_ST) && (timer_d == '0)) begin
      pulso_d = 1'b1;
    end
    if (state_d == ERRO_ST) begin
      erro_d = 1'b1;
    end
  end

  // State, timer, latched code and counter registers.
  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      code_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      code_q  <= code_d;
      count_q <= count_d;
    end
  end

  // Registered outputs.
  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      atuador_q <= '0;
      pulso_q   <= 1'b0;
      ocupado_q <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      atuador_q <= atuador_d;
      pulso_q   <= pulso_d;
      ocupado_q <= ocupado_d;
      erro_q    <= erro_d;
    end
  end

  assign atuador      = atuador_q;
  assign pulso_avanca = pulso_q;
  assign ocupado      = ocupado_q;
  assign erro         = erro_q;
  assign acoes_feitas = count_q;

endmodule

// File: tb/tb_executor_acoes.sv
// Bench for executor_acoes. The reference model turns each accepted request
// into a schedule of per-cycle output frames (DUR_ACAO drive frames, PAUSA
// pause frames with the advance on the last one, an optional settle frame).
// Every cycle one frame is popped and compared with the outputs.
module tb_executor_acoes;

  localparam int DUR_W    = 8;
  localparam int DUR_ACAO = 4;
  localparam int PAUSA    = 2;

  logic       clock_in;
  logic       reset;
  logic       power;
  logic       start;
  logic       continuo;
  logic [2:0] acao_in;
  logic [5:0] atuador;
  logic       pulso_avanca;
  logic       ocupado;
  logic       erro;
  logic [7:0] acoes_feitas;

  executor_acoes #(
    .DUR_W   (DUR_W),
    .DUR_ACAO(DUR_ACAO),
    .PAUSA   (PAUSA)
  ) dut (
    .clock_in    (clock_in),
    .reset       (reset),
    .power       (power),
    .start       (start),
    .continuo    (continuo),
    .acao_in     (acao_in),
    .atuador     (atuador),
    .pulso_avanca(pulso_avanca),
    .ocupado     (ocupado),
    .erro        (erro),
    .acoes_feitas(acoes_feitas)
  );

  // Clock generation.
  initial begin
    clock_in = 1'b0;
    forever #5 clock_in = ~clock_in;
  end

  // Watchdog so the run always ends.
  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected output frame for one clock cycle.
  typedef struct packed {
    logic [5:0] atu;
    logic       pulse;
    logic       busy;
    logic       err;
    logic       esp;
  } frame_t;

  frame_t     exp_q[$];
  frame_t     cur;
  logic [7:0] exp_cnt;

  int n_checks;
  int n_errors;

  // Observation counters and the bench-side action counter.
  int         pulses_seen;
  int         errs_seen;
  logic       follow_ctr;
  int         ctr;
  logic       seen_wrap;
  logic [5:0] atu_seq[$];
  logic [5:0] prev_atu;
  logic [7:0] prev_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Schedule the frames for one accepted request on index a.
  task automatic push_action(input logic [2:0] a);
    frame_t f;
    if (a > 3'd5) begin
      f = '0; f.busy = 1'b1; f.err = 1'b1;
      exp_q.push_back(f);
    end else begin
      for (int i = 0; i < DUR_ACAO; i++) begin
        f = '0; f.busy = 1'b1; f.atu = 6'b000001 << a;
        exp_q.push_back(f);
      end
      for (int i = 0; i < PAUSA; i++) begin
        f = '0; f.busy = 1'b1; f.pulse = (i == PAUSA - 1);
        exp_q.push_back(f);
      end
    end
  endtask

  // Effect of the coming clock edge on the schedule, from the current
  // inputs and the frame being shown now.
  task automatic model_edge();
    frame_t f;
    if (!reset) begin
      exp_q.delete();
      exp_cnt = 8'd0;
    end else if (!power) begin
      exp_q.delete();
    end else if (cur.pulse) begin
      exp_cnt = exp_cnt + 8'd1;
      if (continuo) begin
        f = '0; f.busy = 1'b1; f.esp = 1'b1;
        exp_q.push_back(f);
      end
    end else if (cur.esp || (!cur.busy && start)) begin
      push_action(acao_in);
    end
  endtask

  // Advance one clock and compare all outputs with the scheduled frame.
  task automatic cycle();
    logic pulse_prev;
    model_edge();
    pulse_prev = pulso_avanca;
    prev_atu   = atuador;
    prev_cnt   = acoes_feitas;
    @(posedge clock_in);
    #1;
    if (follow_ctr && pulse_prev) begin
      ctr     = (ctr + 1) % 6;
      acao_in = 3'(ctr);
    end
    if (exp_q.size() > 0) cur = exp_q.pop_front();
    else cur = '0;
    if (pulso_avanca) pulses_seen++;
    if (erro) errs_seen++;
    if (prev_atu == 6'd0 && atuador != 6'd0) atu_seq.push_back(atuador);
    if (prev_cnt == 8'hff && acoes_feitas == 8'h00) seen_wrap = 1'b1;
    check_eq("atuador", 32'(atuador), 32'(cur.atu));
    check_eq("pulso_avanca", 32'(pulso_avanca), 32'(cur.pulse));
    check_eq("ocupado", 32'(ocupado), 32'(cur.busy));
    check_eq("erro", 32'(erro), 32'(cur.err));
    check_eq("acoes_feitas", 32'(acoes_feitas), 32'(exp_cnt));
  endtask

  // One-cycle start request on index a.
  task automatic do_start(input logic [2:0] a);
    acao_in = a;
    start   = 1'b1;
    cycle();
    start   = 1'b0;
  endtask

  // Run until the block is idle, bounded.
  task automatic drain(input string tag);
    int n;
    n = 0;
    while (ocupado && n < 40) begin
      cycle();
      n++;
    end
    check_eq(tag, 32'(ocupado), 32'd0);
  endtask

  int  p0;
  int  e0;
  logic found;

  initial begin
    reset = 1'b0; power = 1'b0; start = 1'b0; continuo = 1'b0; acao_in = 3'd0;
    follow_ctr = 1'b0; ctr = 0; cur = '0; exp_cnt = 8'd0;
    n_checks = 0; n_errors = 0; pulses_seen = 0; errs_seen = 0; seen_wrap = 1'b0;
    prev_atu = '0; prev_cnt = '0;

    // Reset state.
    repeat (3) cycle();
    check_eq("rst_atuador", 32'(atuador), 32'd0);
    check_eq("rst_acoes", 32'(acoes_feitas), 32'd0);
    check_eq("rst_ocupado", 32'(ocupado), 32'd0);
    reset = 1'b1;
    power = 1'b1;
    repeat (2) cycle();

    // Single action on index 3.
    p0 = pulses_seen;
    do_start(3'd3);
    check_eq("single_first_drive", 32'(atuador), 32'h08);
    repeat (7) cycle();
    check_eq("single_pulses", pulses_seen - p0, 1);
    check_eq("single_count", 32'(acoes_feitas), 32'd1);

    // Invalid index.
    p0 = pulses_seen; e0 = errs_seen;
    do_start(3'd6);
    repeat (3) cycle();
    check_eq("invalid_erro_cycles", errs_seen - e0, 1);
    check_eq("invalid_pulses", pulses_seen - p0, 0);
    check_eq("invalid_count", 32'(acoes_feitas), 32'd1);
    do_start(3'd7);
    repeat (2) cycle();
    check_eq("invalid7_erro_cycles", errs_seen - e0, 2);

    // Power drop in the second RUN cycle.
    p0 = pulses_seen;
    do_start(3'd1);
    cycle();
    power = 1'b0;
    cycle();
    check_eq("pwr_atuador", 32'(atuador), 32'd0);
    check_eq("pwr_ocupado", 32'(ocupado), 32'd0);
    power = 1'b1;
    repeat (8) cycle();
    check_eq("pwr_pulses", pulses_seen - p0, 0);
    check_eq("pwr_count", 32'(acoes_feitas), 32'd1);
    do_start(3'd4);
    repeat (7) cycle();
    check_eq("restart_count", 32'(acoes_feitas), 32'd2);

    // Ignored start and acao_in changes while running.
    p0 = pulses_seen;
    do_start(3'd2);
    for (int i = 0; i < 3; i++) begin
      start   = (i % 2 == 0);
      acao_in = 3'd5;
      check_eq("ignored_bit", 32'(atuador), 32'h04);
      cycle();
    end
    start = 1'b0;
    repeat (6) cycle();
    check_eq("ignored_pulses", pulses_seen - p0, 1);
    check_eq("ignored_count", 32'(acoes_feitas), 32'd3);

    // Asynchronous reset in the first pause cycle.
    do_start(3'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (cur.busy && cur.atu == 6'd0 && !cur.pulse && !cur.err && !cur.esp) found = 1'b1;
    end
    check_eq("reach_pause", 32'(found), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_atuador", 32'(atuador), 32'd0);
    check_eq("arst_pulso", 32'(pulso_avanca), 32'd0);
    check_eq("arst_ocupado", 32'(ocupado), 32'd0);
    check_eq("arst_erro", 32'(erro), 32'd0);
    check_eq("arst_acoes", 32'(acoes_feitas), 32'd0);
    exp_q.delete();
    exp_cnt = 8'd0;
    cur = '0;
    p0 = pulses_seen;
    cycle();
    reset = 1'b1;
    repeat (6) cycle();
    check_eq("arst_no_pulse", pulses_seen - p0, 0);
    check_eq("arst_idle", 32'(ocupado), 32'd0);

    // Continuous mode driven by a 0..5 counter that follows pulso_avanca.
    follow_ctr = 1'b1; ctr = 0; continuo = 1'b1;
    atu_seq.delete();
    p0 = pulses_seen;
    do_start(3'd0);
    for (int i = 0; i < 100 && (pulses_seen - p0) < 6; i++) cycle();
    check_eq("cont_six_pulses", pulses_seen - p0, 6);
    cycle();
    check_eq("cont_count", 32'(acoes_feitas), 32'd6);
    for (int i = 0; i < 20 && atu_seq.size() < 7; i++) cycle();
    continuo = 1'b0;
    check_eq("cont_seq_len", atu_seq.size(), 7);
    for (int i = 0; i < atu_seq.size() && i < 7; i++) begin
      check_eq("cont_seq", 32'(atu_seq[i]), 32'(1 << (i % 6)));
    end
    drain("cont_drain");
    check_eq("cont_final_count", 32'(acoes_feitas), 32'd7);

    // Counter wrap over 256 completions.
    seen_wrap = 1'b0;
    continuo = 1'b1;
    p0 = pulses_seen;
    do_start(3'(ctr));
    for (int i = 0; i < 2300 && (pulses_seen - p0) < 256; i++) cycle();
    continuo = 1'b0;
    check_eq("wrap_pulses", pulses_seen - p0, 256);
    drain("wrap_drain");
    check_eq("wrap_seen", 32'(seen_wrap), 32'd1);
    check_eq("wrap_count", 32'(acoes_feitas), 32'd7);

    // Randomized traffic.
    follow_ctr = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      power    = ($urandom_range(0, 39) != 0);
      start    = ($urandom_range(0, 2) == 0);
      acao_in  = 3'($urandom_range(0, 7));
      continuo = ($urandom_range(0, 3) == 0);
      cycle();
    end
    power = 1'b1; start = 1'b0; continuo = 1'b0;
    drain("rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/executor_acoes.md
Name: executor_acoes

Overview:
- Consumer end of the dog-toy action counter: takes the 3-bit action index (0..5) and drives one actuator line for a timed window.
- Runs a timed pause after each action.
- Emits a one-cycle advance pulse that clocks the action counter to its next index.
- Sits between the action counter and the actuator drivers. Optional continuous mode runs the 0..5 cycle autonomously.

Parameters:
- DUR_W, 8, width of the duration and pause timers.
- DUR_ACAO, 50, clock cycles each actuator line is held high (legal range 1..2^DUR_W-1).
- PAUSA, 10, idle cycles between actions (legal range 1..2^DUR_W-1).

Ports:
- clock_in  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- power  input  1  toy enable; 0 forces idle.
- start  input  1  request to execute the action presented on acao_in.
- continuo  input  1  1 = automatically start the next action after each advance.
- acao_in  input  3  action index from the counter; 0..5 valid, 6..7 invalid.
- atuador  output  6  one-hot actuator drive; bit n is high while action n runs.
- pulso_avanca  output  1  one-cycle pulse to advance the action counter.
- ocupado  output  1  high whenever not in IDLE.
- erro  output  1  one-cycle pulse when an invalid index is requested.
- acoes_feitas  output  8  count of completed actions; wraps 255->0.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; timer=0; latched code=0.
  - atuador=0, pulso_avanca=0, ocupado=0, erro=0, acoes_feitas=0.
- States: IDLE, RUN, PAUSA_ST, ESPERA, ERRO_ST.
- IDLE: on an edge with power=1 and start=1, latch acao_in.
  - Index 0..5: go to RUN, timer loaded with DUR_ACAO-1.
  - Index 6..7: go to ERRO_ST.
- RUN:
  - atuador = one-hot of the latched code; timer decrements each cycle.
  - When timer=0: go to PAUSA_ST, timer loaded with PAUSA-1.
  - atuador is therefore high for exactly DUR_ACAO cycles.
- PAUSA_ST:
  - atuador=0; timer decrements each cycle.
  - In the final pause cycle (timer=0), pulso_avanca=1 for exactly one cycle, and acoes_feitas increments at the end of that cycle.
  - Next state is ESPERA if continuo=1, else IDLE.
- ESPERA:
  - Lasts one cycle so the counter can settle.
  - Then behaves as IDLE with start forced to 1: latches the new acao_in and goes to RUN or ERRO_ST.
- ERRO_ST:
  - erro=1 for one cycle; atuador=0; no pulso_avanca; acoes_feitas unchanged.
  - Returns to IDLE.
- Latency: start sampled at edge k -> atuador valid from edge k+1 through edge k+DUR_ACAO. Pause covers the following PAUSA cycles. pulso_avanca is high in the last of those cycles.
- ocupado: high from edge k+1 until the edge on which the block re-enters IDLE; also high in ESPERA and ERRO_ST.
- acao_in is sampled only at IDLE/ESPERA exit; changes during RUN/PAUSA are ignored.
- start while not in IDLE/ESPERA: ignored, not queued.
- power=0 in any state: at the next edge go to IDLE.
  - atuador=0 and timer cleared; no pulso_avanca, no erro.
  - acoes_feitas holds.
  - An action interrupted this way is not counted.
- power=0 and start=1 in IDLE: no start.
- continuo deasserted during RUN/PAUSA: the current action completes normally, then the block returns to IDLE.
- Outputs are registered, glitch-free, and one-hot or zero; atuador is never multi-hot.

Test Plan:
- Bench parameters: DUR_ACAO=4, PAUSA=2.
- Single action: reset release, power=1, acao_in=3, start pulse at edge k.
  - atuador=6'b001000 for edges k+1..k+4, then 0 for two cycles.
  - pulso_avanca=1 only in cycle k+6.
  - acoes_feitas=1; ocupado falls at k+7.
- Continuous cycle: continuo=1, bench models a 0..5 wrapping counter driven by pulso_avanca, start pulse once at index 0.
  - atuador sequence bit0,bit1,...,bit5,bit0, each 4 cycles high, separated by 2-cycle gaps plus 1 ESPERA cycle.
  - acoes_feitas=6 after the sixth advance.
- Invalid index: acao_in=3'b110, start.
  - erro high for exactly one cycle; atuador stays 0; no pulso_avanca; acoes_feitas unchanged; back in IDLE after 2 cycles.
- Power drop mid-RUN: power=0 at the second RUN cycle.
  - Next edge: atuador=0, ocupado=0.
  - No pulso_avanca ever occurs for that action; acoes_feitas unchanged.
  - A restart with power=1 behaves as a fresh action.
- Async reset mid-PAUSA: reset=0 between edges.
  - All outputs 0 immediately, without waiting for a clock edge.
  - pulso_avanca suppressed.
  - After release, the block idles until start.
- Ignored inputs: during RUN, toggle start and change acao_in to 5.
  - Running bit unchanged; exactly one action completes.
- Wrap: 256 completed actions take acoes_feitas from 255 to 0.
